// File: rtl/dsp_pkg.sv
// Shared DSP definitions: voice amplitude FSM states, shift amounts and
// saturation limits used by the voice datapath.
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENV  = 2'd1,
        ST_VOLL = 2'd2,
        ST_VOLR = 2'd3
    } voice_amp_state_t;

    localparam int ENV_SHIFT  = 11;
    localparam int VOL_SHIFT  = 7;

    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

endpackage

// File: rtl/dsp_mul_shift.sv
// Combinational signed multiply, arithmetic (floor) right shift and
// saturation to the signed sample range.
module dsp_mul_shift
    import dsp_pkg::*;
#(
    parameter int A_W   = 17,
    parameter int B_W   = 12,
    parameter int OUT_W = 16
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic        [4:0]       shift,
    output logic signed [OUT_W-1:0] y
);

    localparam int P_W = A_W + B_W;

    localparam logic signed [P_W-1:0] SAT_MAX = P_W'(SAMPLE_MAX);
    localparam logic signed [P_W-1:0] SAT_MIN = P_W'(SAMPLE_MIN);

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;

    // Full-width product, floor shift, clamp into the output range
    always_comb begin
        prod    = P_W'(a) * P_W'(b);
        shifted = prod >>> shift;
        if (shifted > SAT_MAX) begin
            y = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            y = SAT_MIN[OUT_W-1:0];
        end else begin
            y = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/voice_amp.sv
// Per-voice amplitude stage: envelope scaling followed by left/right volume,
// sharing one multiplier over three enabled cycles per sample.
// Optional feature macro: DSP_VOICE_MUTE_EN adds a 'mute' input that forces
// out_l/out_r to zero while voice_out, envx, outx and valid are unchanged.
module voice_amp
    import dsp_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ENV_W    = 11,
    parameter int VOL_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_en,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [ENV_W-1:0]    env_level,
    input  logic [VOL_W-1:0]    vol_l,
    input  logic [VOL_W-1:0]    vol_r,
`ifdef DSP_VOICE_MUTE_EN
    input  logic                mute,
`endif
    output logic [SAMPLE_W-1:0] voice_out,
    output logic [SAMPLE_W-1:0] out_l,
    output logic [SAMPLE_W-1:0] out_r,
    output logic                valid,
    output logic                busy,
    output logic [7:0]          envx,
    output logic [7:0]          outx
);

    localparam int A_W = SAMPLE_W + 1;
    localparam int B_W = ENV_W + 1;

    voice_amp_state_t state;

    logic [SAMPLE_W-1:0] smp_q;
    logic [ENV_W-1:0]    env_q;
    logic [VOL_W-1:0]    vl_q;
    logic [VOL_W-1:0]    vr_q;
    logic                mute_q;
    logic                mute_in;

    logic signed [A_W-1:0]      mul_a;
    logic signed [B_W-1:0]      mul_b;
    logic        [4:0]          mul_sh;
    logic signed [SAMPLE_W-1:0] mul_y;

`ifdef DSP_VOICE_MUTE_EN
    assign mute_in = mute;
`else
    assign mute_in = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

    // Operand mux for the shared multiplier, selected by the current stage
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_sh = '0;
        case (state)
            ST_ENV: begin
                // Sample LSB is dropped; envelope is zero-extended to stay positive
                mul_a  = {smp_q[SAMPLE_W-1], smp_q[SAMPLE_W-1:1], 1'b0};
                mul_b  = {1'b0, env_q};
                mul_sh = 5'(ENV_SHIFT);
            end
            ST_VOLL: begin
                mul_a  = {voice_out[SAMPLE_W-1], voice_out};
                mul_b  = {{(B_W-VOL_W){vl_q[VOL_W-1]}}, vl_q};
                mul_sh = 5'(VOL_SHIFT);
            end
            ST_VOLR: begin
                mul_a  = {voice_out[SAMPLE_W-1], voice_out};
                mul_b  = {{(B_W-VOL_W){vr_q[VOL_W-1]}}, vr_q};
                mul_sh = 5'(VOL_SHIFT);
            end
            default: begin
                mul_a  = '0;
                mul_b  = '0;
                mul_sh = '0;
            end
        endcase
    end

    dsp_mul_shift #(
        .A_W   (A_W),
        .B_W   (B_W),
        .OUT_W (SAMPLE_W)
    ) u_mul (
        .a     (mul_a),
        .b     (mul_b),
        .shift (mul_sh),
        .y     (mul_y)
    );

    // Sequencer: latch inputs, then envelope, left and right stages
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            smp_q     <= '0;
            env_q     <= '0;
            vl_q      <= '0;
            vr_q      <= '0;
            mute_q    <= 1'b0;
            voice_out <= '0;
            out_l     <= '0;
            out_r     <= '0;
            envx      <= '0;
            outx      <= '0;
            valid     <= 1'b0;
        end else begin
            // valid is a single-clock pulse regardless of cpu_en
            valid <= 1'b0;
            if (cpu_en) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            smp_q  <= sample;
                            env_q  <= env_level;
                            vl_q   <= vol_l;
                            vr_q   <= vol_r;
                            mute_q <= mute_in;
                            state  <= ST_ENV;
                        end
                    end
                    ST_ENV: begin
                        voice_out <= mul_y;
                        state     <= ST_VOLL;
                    end
                    ST_VOLL: begin
                        out_l <= mute_q ? '0 : mul_y;
                        state <= ST_VOLR;
                    end
                    ST_VOLR: begin
                        out_r <= mute_q ? '0 : mul_y;
                        envx  <= {1'b0, env_q[ENV_W-1:ENV_W-7]};
                        outx  <= voice_out[SAMPLE_W-1:SAMPLE_W-8];
                        valid <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_amp.sv
// Scoreboard bench for voice_amp: directed vectors push hand-computed results,
// a monitor pops and compares on every valid pulse.
module tb_voice_amp;

    typedef struct packed {
        logic [15:0] vo;
        logic [15:0] ol;
        logic [15:0] orr;
        logic [7:0]  envx;
        logic [7:0]  outx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic        start;
    logic [15:0] sample;
    logic [10:0] env_level;
    logic [7:0]  vol_l;
    logic [7:0]  vol_r;
`ifdef DSP_VOICE_MUTE_EN
    logic        mute;
`endif
    logic [15:0] voice_out;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        valid;
    logic        busy;
    logic [7:0]  envx;
    logic [7:0]  outx;

    logic signed [16:0] ma;
    logic signed [11:0] mb;
    logic        [4:0]  msh;
    logic signed [15:0] my;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    voice_amp #(
        .SAMPLE_W (16),
        .ENV_W    (11),
        .VOL_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_en    (cpu_en),
        .start     (start),
        .sample    (sample),
        .env_level (env_level),
        .vol_l     (vol_l),
        .vol_r     (vol_r),
`ifdef DSP_VOICE_MUTE_EN
        .mute      (mute),
`endif
        .voice_out (voice_out),
        .out_l     (out_l),
        .out_r     (out_r),
        .valid     (valid),
        .busy      (busy),
        .envx      (envx),
        .outx      (outx)
    );

    dsp_mul_shift #(
        .A_W   (17),
        .B_W   (12),
        .OUT_W (16)
    ) u_mul_chk (
        .a     (ma),
        .b     (mb),
        .shift (msh),
        .y     (my)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1, expected no pending result");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("voice_out", {16'd0, voice_out}, {16'd0, e.vo});
                chk("out_l",     {16'd0, out_l},     {16'd0, e.ol});
                chk("out_r",     {16'd0, out_r},     {16'd0, e.orr});
                chk("envx",      {24'd0, envx},      {24'd0, e.envx});
                chk("outx",      {24'd0, outx},      {24'd0, e.outx});
                chk("busy_at_valid", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic set_inputs(input logic [15:0] s, input logic [10:0] e,
                              input logic [7:0] vl, input logic [7:0] vr, input logic m);
        sample    = s;
        env_level = e;
        vol_l     = vl;
        vol_r     = vr;
`ifdef DSP_VOICE_MUTE_EN
        mute      = m;
`else
        if (m) $display("note: mute requested in a build without mute support");
`endif
    endtask

    task automatic launch(input logic [15:0] s, input logic [10:0] e,
                          input logic [7:0] vl, input logic [7:0] vr, input logic m);
        set_inputs(s, e, vl, vr, m);
        cpu_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (busy && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input string name, input logic [15:0] s, input logic [10:0] e,
                           input logic [7:0] vl, input logic [7:0] vr, input logic m,
                           input exp_t ex);
        q.push_back(ex);
        launch(s, e, vl, vr, m);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        int k;
        logic got;

        reset  = 1'b1;
        cpu_en = 1'b0;
        start  = 1'b0;
        set_inputs(16'h0, 11'h0, 8'h0, 8'h0, 1'b0);
        ma = '0; mb = '0; msh = '0;
        repeat (3) @(negedge clk);
        chk("rst_voice_out", {16'd0, voice_out}, 32'd0);
        chk("rst_out_l",     {16'd0, out_l},     32'd0);
        chk("rst_out_r",     {16'd0, out_r},     32'd0);
        chk("rst_envx",      {24'd0, envx},      32'd0);
        chk("rst_outx",      {24'd0, outx},      32'd0);
        chk("rst_valid",     {31'd0, valid},     32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full-scale positive, full-scale negative, mid-level and corner vectors
        run_vec("t_maxpos", 16'h7fff, 11'd2047, 8'd127, 8'd127, 1'b0,
                '{vo:16'h7FEE, ol:16'h7EEE, orr:16'h7EEE, envx:8'h7f, outx:8'h7f});
        run_vec("t_maxneg", 16'h8000, 11'd2047, 8'h80, 8'd127, 1'b0,
                '{vo:16'h8010, ol:16'h7FF0, orr:16'h810F, envx:8'h7f, outx:8'h80});
        run_vec("t_mid", 16'd1000, 11'd1024, 8'd64, 8'hC0, 1'b0,
                '{vo:16'h01F4, ol:16'h00FA, orr:16'hFF06, envx:8'h40, outx:8'h01});
        run_vec("t_odd_neg", 16'hFFFD, 11'd1024, 8'd127, 8'd1, 1'b0,
                '{vo:16'hFFFE, ol:16'hFFFE, orr:16'hFFFF, envx:8'h40, outx:8'hFF});
        run_vec("t_env0", 16'd1234, 11'd0, 8'd100, 8'h9C, 1'b0,
                '{vo:16'h0000, ol:16'h0000, orr:16'h0000, envx:8'h00, outx:8'h00});
        run_vec("t_vol0", 16'h4000, 11'd2047, 8'd0, 8'hFF, 1'b0,
                '{vo:16'h3FF8, ol:16'h0000, orr:16'hFF80, envx:8'h7f, outx:8'h3F});

        // Saturation corner, only reachable directly on the shared multiplier
        ma = -17'sd32768; mb = -12'sd128; msh = 5'd7;
        #1 chk("sat_pos", {16'd0, my}, 32'h7FFF);
        ma = -17'sd32768; mb = 12'sd127;  msh = 5'd7;
        #1 chk("neg_nosat", {16'd0, my}, 32'h8100);

        // start with cpu_en low must not be accepted
        set_inputs(16'h1234, 11'd100, 8'd1, 8'd1, 1'b0);
        cpu_en = 1'b0;
        start  = 1'b1;
        repeat (2) @(negedge clk);
        start  = 1'b0;
        chk("start_no_en", {31'd0, busy}, 32'd0);

        // cpu_en 1-of-3: latency in enabled cycles; start while busy ignored
        q.push_back('{vo:16'h7FEE, ol:16'h7EEE, orr:16'h7EEE, envx:8'h7f, outx:8'h7f});
        set_inputs(16'h7fff, 11'd2047, 8'd127, 8'd127, 1'b0);
        en_cnt = 0;
        k      = 0;
        got    = 1'b0;
        while (!got && k < 40) begin
            cpu_en = (k % 3 == 0);
            start  = (k == 0) || (k == 6);
            if (k == 6) set_inputs(16'h8000, 11'd10, 8'h80, 8'h80, 1'b0);
            if (cpu_en) en_cnt++;
            @(negedge clk);
            k++;
            if (valid) begin
                got = 1'b1;
                chk("latency_en_cycles", en_cnt, 32'd4);
            end
        end
        chk("latency_seen", {31'd0, got}, 32'd1);
        start  = 1'b0;
        cpu_en = 1'b1;
        @(negedge clk);
        chk("valid_one_clk", {31'd0, valid}, 32'd0);
        chk("busy_ignored_start", {31'd0, busy}, 32'd0);

        // Back-to-back: start on the cycle valid is high is accepted
        q.push_back('{vo:16'h01F4, ol:16'h00FA, orr:16'hFF06, envx:8'h40, outx:8'h01});
        launch(16'd1000, 11'd1024, 8'd64, 8'hC0, 1'b0);
        wait_done("b2b_first");
        q.push_back('{vo:16'hFFFE, ol:16'hFFFE, orr:16'hFFFF, envx:8'h40, outx:8'hFF});
        launch(16'hFFFD, 11'd1024, 8'd127, 8'd1, 1'b0);
        chk("b2b_accepted", {31'd0, busy}, 32'd1);
        wait_done("b2b_second");

        // Reset while in VOLL discards the sample
        launch(16'h7fff, 11'd2047, 8'd127, 8'd127, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_voice_out", {16'd0, voice_out}, 32'd0);
        chk("midrst_out_l",     {16'd0, out_l},     32'd0);
        chk("midrst_out_r",     {16'd0, out_r},     32'd0);
        chk("midrst_envx",      {24'd0, envx},      32'd0);
        chk("midrst_outx",      {24'd0, outx},      32'd0);
        chk("midrst_busy",      {31'd0, busy},      32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        run_vec("t_after_rst", 16'h4000, 11'd2047, 8'd0, 8'hFF, 1'b0,
                '{vo:16'h3FF8, ol:16'h0000, orr:16'hFF80, envx:8'h7f, outx:8'h3F});

`ifdef DSP_VOICE_MUTE_EN
        run_vec("t_mute", 16'd1000, 11'd1024, 8'd64, 8'd64, 1'b1,
                '{vo:16'h01F4, ol:16'h0000, orr:16'h0000, envx:8'h40, outx:8'h01});
        run_vec("t_unmute", 16'd1000, 11'd1024, 8'd64, 8'd64, 1'b0,
                '{vo:16'h01F4, ol:16'h00FA, orr:16'h00FA, envx:8'h40, outx:8'h01});
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
